frame_pad_writer: RTL and testbench
===================================

Name: frame_pad_writer

Overview:
- Upstream feeder for the `bus` memory-write path.
- Accepts a raster stream of 8-bit pixels and inserts a 1-pixel border of PAD_VALUE around the frame, giving (WIDTH+2)x(HEIGHT+2) bytes.
- Packs those bytes into 32-bit words and issues them one at a time through the bus write handshake: write pulse, wait for ctrl done and buffer not full, then a user_write_buffer commit.

Parameters:
- WIDTH, 320, active pixels per row.
- HEIGHT, 240, active rows per frame.
- FIFO_DEPTH, 4, packed-word FIFO depth (power of 2, at least 2).
- PAD_VALUE, 8'd0, byte used for the border and for tail fill.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy=1.
- in_pixel  in  8  active pixel, raster order.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  in_pixel is consumed on a cycle where in_valid and in_ready are both 1.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last word is committed.
- write  out  1  bus write-request pulse.
- user_write_buffer  out  1  bus commit pulse.
- oData  out  32  word presented to the bus.
- oValid  out  1  oData is valid.
- write_ctrl_done  in  1  bus write controller ready.
- write_buffer_full  in  1  bus buffer full.

Behaviour:
- Reset (reset_n=0 at a clk edge), including mid-frame:
  - All outputs go to 0 and the FIFO empties.
  - Counters and the packer clear, and both FSMs return to IDLE.
  - No partial frame is resumed after reset.
- Generator FSM (G_IDLE, G_RUN, G_FLUSH):
  - start in G_IDLE clears row and col and moves to G_RUN.
  - row runs 0..HEIGHT+1 and col runs 0..WIDTH+1; col wraps to 0 and row increments after col=WIDTH+1.
  - Border position (row 0, row HEIGHT+1, col 0 or col WIDTH+1): PAD_VALUE is emitted without consuming input; one byte per cycle unless stalled.
  - Interior position: in_ready=1 unless stalled; a byte is emitted only on in_valid & in_ready.
  - in_ready is 0 on border positions and outside G_RUN.
- Packer:
  - Byte k of each group lands at oData bits [8k+7:8k] (little-endian).
  - The 4th byte pushes the word into the FIFO in the same cycle.
  - Stall: when the FIFO is full and the packer holds 3 bytes, the position does not advance and in_ready=0.
- Tail:
  - After position (HEIGHT+1, WIDTH+1), a non-empty partial word is filled with PAD_VALUE in its upper bytes and pushed, via G_FLUSH.
  - Total words = ceil((WIDTH+2)*(HEIGHT+2)/4); for the default this is exactly 19481.
- Bus FSM (B_IDLE, B_REQ, B_WAIT, B_HOLD, B_COMMIT):
  - B_IDLE: moves to B_REQ when the FIFO is not empty.
  - B_REQ: write=1 for exactly one cycle; oData=FIFO head; oValid=1.
  - B_WAIT: leaves when write_ctrl_done=1 and write_buffer_full=0. It stays indefinitely otherwise. If ctrl_done and full are both seen, it stays.
  - B_HOLD: one cycle, oValid held.
  - B_COMMIT: user_write_buffer=1 for one cycle and the FIFO pops. The state then goes to B_IDLE, or directly to B_REQ if more words are pending.
  - oValid is 1 and oData stable throughout B_REQ..B_COMMIT, and 0 in B_IDLE.
  - write and user_write_buffer are never high in the same cycle.
- Push and pop may occur in the same cycle when the FIFO is full: net count is unchanged and the push is allowed.
- Completion:
  - frame_done pulses the cycle after the commit of the final word; busy drops in the same cycle.
  - Words committed per frame equals the total word count exactly.

Test Plan:
- WIDTH=4, HEIGHT=2; start; pixels 1..8 streamed with in_valid=1; bus returns ctrl_done 2 cycles after each write, full=0 -> commits in order: 0x00000000, 0x01000000, 0x00040302, 0x07060500, 0x00000008, 0x00000000; frame_done after the 6th commit.
- Same setup, write_buffer_full=1 for 20 cycles mid-frame -> FIFO fills, in_ready=0, no input lost; word sequence identical to the first test.
- WIDTH=3, HEIGHT=1 (15 bytes), pixels 0xA,0xB,0xC -> 4 words; last word = 0x00000000 with its final byte tail-filled; exactly 4 commits.
- in_valid toggled 1/0 each cycle -> output identical to the first test; in_ready low on every border cycle.
- reset_n=0 for one cycle after the 3rd commit -> all outputs 0 next cycle; a new start produces the full 6-word sequence from 0x00000000.
- start asserted while busy -> ignored; exactly one frame_done and 6 commits.

Source files
------------

// File: rtl/frame_pad_writer_if.sv
// Memory-write bus handshake between the frame padder and the bus write controller.
interface frame_pad_writer_if;
  logic        write;
  logic        user_write_buffer;
  logic [31:0] oData;
  logic        oValid;
  logic        write_ctrl_done;
  logic        write_buffer_full;

  modport master (
    output write, user_write_buffer, oData, oValid,
    input  write_ctrl_done, write_buffer_full
  );

  modport slave (
    input  write, user_write_buffer, oData, oValid,
    output write_ctrl_done, write_buffer_full
  );
endinterface

// File: rtl/frame_pad_writer.sv
// Pads a raster pixel stream with a one-pixel border, packs bytes into
// little-endian 32-bit words and writes them out over the bus handshake.
module frame_pad_writer #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  PAD_VALUE  = 8'd0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [7:0]                 in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       frame_done,
  frame_pad_writer_if.master         bus
);

  localparam int unsigned RW   = $clog2(HEIGHT + 2);
  localparam int unsigned CW   = $clog2(WIDTH + 2);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_FLUSH} gen_state_t;
  typedef enum logic [2:0] {B_IDLE, B_REQ, B_WAIT, B_HOLD, B_COMMIT} bus_state_t;

  gen_state_t       gen_q, gen_d;
  bus_state_t       bus_q;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [23:0]      pack_q, pack_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             in_ready_q, busy_q, frame_done_q;
  logic             write_q, commit_q, ovalid_q;
  logic [31:0]      odata_q;

  logic             push_c, pop_c, full_c, stall_c, emit_c, done_c, accept_c;
  logic [7:0]       emit_byte_c;
  logic [31:0]      push_word_c;

  function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (r == '0) || (r == RW'(HEIGHT + 1)) || (c == '0) || (c == CW'(WIDTH + 1));
  endfunction

  // Interior position with room to take a byte (a pending pop frees a slot).
  function automatic logic ready_f(input gen_state_t g, input logic [RW-1:0] r,
                                   input logic [CW-1:0] c, input logic [CNTW-1:0] n,
                                   input logic [1:0] k, input logic pop);
    return (g == G_RUN) && !is_border(r, c) &&
           !((n == CNTW'(FIFO_DEPTH)) && (k == 2'd3) && !pop);
  endfunction

  assign pop_c    = (bus_q == B_COMMIT);
  assign full_c   = (count_q == CNTW'(FIFO_DEPTH));
  assign count_d  = count_q + CNTW'(push_c) - CNTW'(pop_c);
  assign accept_c = (gen_q == G_IDLE) && start && !busy_q;
  assign done_c   = busy_q && pop_c && (count_d == '0) && (gen_d == G_IDLE);

  // Border/pixel generator, byte packer and tail flush.
  always_comb begin
    gen_d       = gen_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    push_c      = 1'b0;
    push_word_c = '0;
    emit_c      = 1'b0;
    emit_byte_c = PAD_VALUE;
    stall_c     = full_c && (cnt_q == 2'd3) && !pop_c;
    case (gen_q)
      G_IDLE: begin
        if (accept_c) begin
          gen_d = G_RUN;
          row_d = '0;
          col_d = '0;
        end
      end
      G_RUN: begin
        if (is_border(row_q, col_q)) begin
          emit_c = !stall_c;
        end else begin
          emit_c      = in_valid && !stall_c;
          emit_byte_c = in_pixel;
        end
        if (emit_c) begin
          if (cnt_q == 2'd3) begin
            push_c      = 1'b1;
            push_word_c = {emit_byte_c, pack_q};
            cnt_d       = 2'd0;
          end else begin
            pack_d[{cnt_q, 3'b000} +: 8] = emit_byte_c;
            cnt_d                        = cnt_q + 2'd1;
          end
          if (col_q == CW'(WIDTH + 1)) begin
            col_d = '0;
            if (row_q == RW'(HEIGHT + 1)) gen_d = G_FLUSH;
            else                          row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      G_FLUSH: begin
        if (cnt_q == 2'd0) begin
          gen_d = G_IDLE;
        end else if (!full_c || pop_c) begin
          push_c = 1'b1;
          for (int k = 0; k < 3; k++) begin
            push_word_c[8*k +: 8] = (2'(k) < cnt_q) ? pack_q[8*k +: 8] : PAD_VALUE;
          end
          push_word_c[31:24] = PAD_VALUE;
          cnt_d              = 2'd0;
          gen_d              = G_IDLE;
        end
      end
      default: gen_d = G_IDLE;
    endcase
  end

  // Generator state, packer, FIFO pointers and frame status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gen_q        <= G_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      pack_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      gen_q        <= gen_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      pack_q       <= pack_d;
      count_q      <= count_d;
      if (push_c) wptr_q <= wptr_q + AW'(1);
      if (pop_c)  rptr_q <= rptr_q + AW'(1);
      in_ready_q   <= ready_f(gen_d, row_d, col_d, count_d, cnt_d, bus_q == B_HOLD);
      frame_done_q <= done_c;
      if (accept_c)    busy_q <= 1'b1;
      else if (done_c) busy_q <= 1'b0;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wptr_q] <= push_word_c;
  end

  // Bus write handshake: request, wait for controller, hold, commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_q    <= B_IDLE;
      write_q  <= 1'b0;
      commit_q <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      write_q  <= 1'b0;
      commit_q <= 1'b0;
      case (bus_q)
        B_IDLE: begin
          ovalid_q <= 1'b0;
          if (count_q != '0) begin
            bus_q    <= B_REQ;
            write_q  <= 1'b1;
            ovalid_q <= 1'b1;
            odata_q  <= mem_q[rptr_q];
          end
        end
        B_REQ: bus_q <= B_WAIT;
        B_WAIT: begin
          if (bus.write_ctrl_done && !bus.write_buffer_full) bus_q <= B_HOLD;
        end
        B_HOLD: begin
          bus_q    <= B_COMMIT;
          commit_q <= 1'b1;
        end
        B_COMMIT: begin
          if (count_q > CNTW'(1)) begin
            bus_q   <= B_REQ;
            write_q <= 1'b1;
            odata_q <= mem_q[rptr_q + AW'(1)];
          end else begin
            bus_q    <= B_IDLE;
            ovalid_q <= 1'b0;
          end
        end
        default: bus_q <= B_IDLE;
      endcase
    end
  end

  assign in_ready              = in_ready_q;
  assign busy                  = busy_q;
  assign frame_done            = frame_done_q;
  assign bus.write             = write_q;
  assign bus.user_write_buffer = commit_q;
  assign bus.oValid            = ovalid_q;
  assign bus.oData             = odata_q;

endmodule

// File: tb/tb_frame_pad_writer.sv
// Directed bench for frame_pad_writer: a 4x2 frame on instance A and a 3x1 frame on instance B.
module tb_frame_pad_writer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instance A: 4x2 active, 6x4 padded, 6 words.
  logic       start_a, in_valid_a, in_ready_a, busy_a, frame_done_a;
  logic [7:0] in_pixel_a;
  frame_pad_writer_if bus_a ();

  frame_pad_writer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .PAD_VALUE(8'd0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .in_pixel(in_pixel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .busy(busy_a),
    .frame_done(frame_done_a), .bus(bus_a)
  );

  // Instance B: 3x1 active, 5x3 padded, 15 bytes -> 4 words.
  logic       start_b, in_valid_b, in_ready_b, busy_b, frame_done_b;
  logic [7:0] in_pixel_b;
  frame_pad_writer_if bus_b ();

  frame_pad_writer #(.WIDTH(3), .HEIGHT(1), .FIFO_DEPTH(4), .PAD_VALUE(8'd0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_pixel(in_pixel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .busy(busy_b),
    .frame_done(frame_done_b), .bus(bus_b)
  );

  assign bus_b.write_ctrl_done   = 1'b1;
  assign bus_b.write_buffer_full = 1'b0;

  // Hand-computed padded frames.
  logic [31:0] exp_a [6] = '{32'h00000000, 32'h01000000, 32'h00040302,
                             32'h07060500, 32'h00000008, 32'h00000000};
  logic [31:0] exp_b [4] = '{32'h00000000, 32'h0B0A0000, 32'h0000000C, 32'h00000000};
  logic [7:0]  pix_b [3] = '{8'h0A, 8'h0B, 8'h0C};

  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  int done_cnt_a = 0, done_cnt_b = 0;
  int viol_a = 0, viol_b = 0;
  int wcnt_a = 0;
  int ready_err = 0;

  // Bus controller model for A: ctrl_done two cycles after each write pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      wcnt_a                = 0;
      bus_a.write_ctrl_done = 1'b0;
    end else begin
      if (bus_a.write) begin
        wcnt_a                = 2;
        bus_a.write_ctrl_done = 1'b0;
      end else if (wcnt_a > 0) begin
        wcnt_a--;
        if (wcnt_a == 0) bus_a.write_ctrl_done = 1'b1;
      end
      if (bus_a.user_write_buffer) bus_a.write_ctrl_done = 1'b0;
    end
  end

  // Commit capture and frame_done bookkeeping for A.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_a.user_write_buffer) q_a.push_back(bus_a.oData);
      if ((bus_a.write && bus_a.user_write_buffer) ||
          ((bus_a.write || bus_a.user_write_buffer) && !bus_a.oValid)) viol_a++;
      if (frame_done_a) begin
        done_cnt_a++;
        check_eq("a_done_after_last_commit", 32'(q_a.size()), 32'd6);
        check_eq("a_busy_drops_with_done", 32'(busy_a), 32'd0);
      end
    end
  end

  // Commit capture and frame_done bookkeeping for B.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_b.user_write_buffer) q_b.push_back(bus_b.oData);
      if ((bus_b.write && bus_b.user_write_buffer) ||
          ((bus_b.write || bus_b.user_write_buffer) && !bus_b.oValid)) viol_b++;
      if (frame_done_b) begin
        done_cnt_b++;
        check_eq("b_done_after_last_commit", 32'(q_b.size()), 32'd4);
      end
    end
  end

  // Streams pixels 1..8 into A; optionally checks in_ready against a position model.
  task automatic stream_a(input bit toggle, input bit model, input bit restart);
    int  p, pix, cyc, r, c;
    bit  interior, acc;
    p = 0; pix = 0; cyc = 0; ready_err = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("a_busy_after_start", 32'(busy_a), 32'd1);
    while (((model && p < 24) || pix < 8) && cyc < 400) begin
      r = p / 6;
      c = p % 6;
      interior = (r >= 1) && (r <= 2) && (c >= 1) && (c <= 4);
      if (model && p < 24 && (in_ready_a !== interior)) ready_err++;
      in_valid_a = (pix < 8) && (!toggle || (cyc % 2 == 0));
      in_pixel_a = 8'(pix + 1);
      acc = in_valid_a && in_ready_a;
      if (acc) pix++;
      if (!interior || acc) p++;
      start_a = restart && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    in_valid_a = 1'b0;
    start_a    = 1'b0;
    check_eq("a_pixels_taken", 32'(pix), 32'd8);
    if (model) check_eq("a_in_ready_pattern_errors", 32'(ready_err), 32'd0);
  endtask

  task automatic wait_done_a(input int base, input string tag);
    int n = 0;
    while (done_cnt_a == base && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done_cnt_a - base), 32'd1);
  endtask

  task automatic check_frame_a(input string tag);
    check_eq({tag, "_count"}, 32'(q_a.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), (i < q_a.size()) ? q_a[i] : 32'hxxxxxxxx, exp_a[i]);
    end
  endtask

  task automatic check_idle_outputs_a(input string tag);
    check_eq({tag, "_ctrl"}, {26'd0, busy_a, in_ready_a, frame_done_a, bus_a.write,
                              bus_a.user_write_buffer, bus_a.oValid}, 32'd0);
    check_eq({tag, "_odata"}, bus_a.oData, 32'd0);
  endtask

  initial begin
    int base, c0, c1, n, pix, cyc;
    reset_n = 1'b0;
    start_a = 1'b0; in_valid_a = 1'b0; in_pixel_a = 8'd0;
    start_b = 1'b0; in_valid_b = 1'b0; in_pixel_b = 8'd0;
    bus_a.write_buffer_full = 1'b0;
    c0 = 0; c1 = 0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_idle_outputs_a("a_reset");
    check_eq("b_reset_ctrl", {26'd0, busy_b, in_ready_b, frame_done_b, bus_b.write,
                              bus_b.user_write_buffer, bus_b.oValid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame with continuous input.
    base = done_cnt_a; q_a.delete();
    stream_a(1'b0, 1'b1, 1'b0);
    wait_done_a(base, "a_basic_done");
    check_frame_a("a_basic");

    // Buffer full for 20 cycles mid-frame.
    base = done_cnt_a; q_a.delete();
    fork
      stream_a(1'b0, 1'b0, 1'b0);
      begin
        repeat (8) @(negedge clk);
        bus_a.write_buffer_full = 1'b1;
        repeat (3) @(negedge clk);
        c0 = q_a.size();
        repeat (17) @(negedge clk);
        c1 = q_a.size();
        bus_a.write_buffer_full = 1'b0;
      end
    join
    check_eq("a_no_commit_while_full", 32'(c1), 32'(c0));
    wait_done_a(base, "a_full_done");
    check_frame_a("a_full");

    // in_valid toggling every cycle.
    base = done_cnt_a; q_a.delete();
    stream_a(1'b1, 1'b1, 1'b0);
    wait_done_a(base, "a_toggle_done");
    check_frame_a("a_toggle");

    // Reset after the third commit, then a fresh frame.
    base = done_cnt_a; q_a.delete();
    stream_a(1'b0, 1'b0, 1'b0);
    n = 0;
    while (q_a.size() < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_third_commit_seen", 32'(q_a.size() >= 3), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs_a("a_midframe_reset");
    reset_n = 1'b1;
    q_a.delete();
    repeat (30) @(negedge clk);
    check_eq("a_no_resume_after_reset", 32'(q_a.size()), 32'd0);
    check_eq("a_no_done_after_reset", 32'(done_cnt_a - base), 32'd0);
    stream_a(1'b0, 1'b1, 1'b0);
    wait_done_a(base, "a_post_reset_done");
    check_frame_a("a_post_reset");

    // start while busy is ignored.
    base = done_cnt_a; q_a.delete();
    stream_a(1'b0, 1'b1, 1'b1);
    wait_done_a(base, "a_restart_done");
    repeat (40) @(negedge clk);
    check_eq("a_restart_single_done", 32'(done_cnt_a - base), 32'd1);
    check_frame_a("a_restart");

    // 3x1 frame with tail fill on B.
    q_b.delete();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    pix = 0; cyc = 0;
    while (pix < 3 && cyc < 200) begin
      in_valid_b = 1'b1;
      in_pixel_b = pix_b[pix];
      if (in_ready_b) pix++;
      @(negedge clk);
      cyc++;
    end
    in_valid_b = 1'b0;
    check_eq("b_pixels_taken", 32'(pix), 32'd3);
    n = 0;
    while (done_cnt_b == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check_eq("b_done_count", 32'(done_cnt_b), 32'd1);
    check_eq("b_commit_count", 32'(q_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("b_w%0d", i), (i < q_b.size()) ? q_b[i] : 32'hxxxxxxxx, exp_b[i]);
    end

    check_eq("a_handshake_violations", 32'(viol_a), 32'd0);
    check_eq("b_handshake_violations", 32'(viol_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
